hiscore_upload_src: RTL and testbench

- Core-side source for HPS upload transfers: answers HPS byte-read requests on the ioctl interface with bytes fetched from core RAM (high-score / NVRAM region).
- Write-side counterpart of the existing ioctl download / DIP-load logic; instantiated in emu next to hps_io.
- Requests a core pause so the uploaded snapshot is consistent, and stretches each read with ioctl_wait until its byte is valid.

---
 rtl/hiscore_upload_src_pkg.sv | 23 ++
 rtl/hiscore_upload_src_if.sv | 28 ++
 rtl/hiscore_upload_src.sv | 116 +++++++++++
 tb/tb_hiscore_upload_src.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hiscore_upload_src_pkg.sv
// Shared types and constants for the high-score / NVRAM upload source.
// Holds the controller state encoding and the ioctl slot numbers used across emu.
package hiscore_upload_src_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPause,
    StReady,
    StFetch
  } state_e;

  localparam logic [7:0] NvramIndex = 8'd4;
  localparam logic [7:0] RomIndex   = 8'd0;
  localparam logic [7:0] DipIndex   = 8'd254;

  localparam int unsigned IoctlAddrW = 25;

  // Range check on the full ioctl address, so aliased high addresses pad instead of wrapping.
  function automatic logic addr_in_range(logic [IoctlAddrW-1:0] addr, int unsigned size);
    return {7'd0, addr} < size;
  endfunction

endpackage

// File: rtl/hiscore_upload_src_if.sv
// Bundle of the ioctl upload, core pause and core RAM read signals.
// The slave side is the upload source; the master side is hps_io plus the core.
interface hiscore_upload_src_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              ioctl_upload;
  logic [7:0]        ioctl_index;
  logic              ioctl_rd;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic              pause_req;
  logic              pause_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic [7:0]        ram_do;
  logic              busy;

  modport master (
    output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, pause_ack, ram_do,
    input  ioctl_din, ioctl_wait, pause_req, ram_addr, ram_rd, busy
  );

  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, pause_ack, ram_do,
    output ioctl_din, ioctl_wait, pause_req, ram_addr, ram_rd, busy
  );
endinterface

// File: rtl/hiscore_upload_src.sv
// Answers HPS upload byte reads with data fetched from core RAM, pausing the core
// for a consistent snapshot and stretching each read with ioctl_wait.
module hiscore_upload_src
  import hiscore_upload_src_pkg::*;
#(
  parameter logic [7:0]  INDEX   = NvramIndex,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned SIZE    = 1024,
  parameter int unsigned RAM_LAT = 2,
  parameter logic [7:0]  PAD     = 8'hFF
) (
  input logic               clk_sys,
  input logic               reset,
  hiscore_upload_src_if.slave bus
);

  localparam int unsigned CntW = 3;

  state_e                  state;
  logic                    sel;
  logic                    sel_q;
  logic                    pend;
  logic [IoctlAddrW-1:0]   pend_addr;
  logic [CntW-1:0]         cnt;
  logic                    req;
  logic [IoctlAddrW-1:0]   req_addr;

  assign sel      = bus.ioctl_upload && (bus.ioctl_index == INDEX);
  assign req      = pend || bus.ioctl_rd;
  assign req_addr = pend ? pend_addr : bus.ioctl_addr;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state          <= StIdle;
      sel_q          <= 1'b0;
      pend           <= 1'b0;
      pend_addr      <= '0;
      cnt            <= '0;
      bus.ioctl_din  <= '0;
      bus.ioctl_wait <= 1'b0;
      bus.pause_req  <= 1'b0;
      bus.ram_addr   <= '0;
      bus.ram_rd     <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      sel_q      <= sel;
      bus.ram_rd <= 1'b0;
      if (!sel) begin
        // Session closed: drop everything, including an in-flight fetch; ioctl_din keeps its byte.
        if (state != StIdle) begin
          state          <= StIdle;
          pend           <= 1'b0;
          bus.pause_req  <= 1'b0;
          bus.ioctl_wait <= 1'b0;
          bus.busy       <= 1'b0;
        end
      end else begin
        unique case (state)
          StIdle: begin
            if (!sel_q) begin
              bus.pause_req <= 1'b1;
              bus.busy      <= 1'b1;
              state         <= StPause;
            end
          end
          StPause: begin
            if (bus.ioctl_rd && !pend) begin
              pend           <= 1'b1;
              pend_addr      <= bus.ioctl_addr;
              bus.ioctl_wait <= 1'b1;
            end
            if (bus.pause_ack) begin
              state <= StReady;
            end
          end
          StReady: begin
            if (req) begin
              if (!bus.pause_ack) begin
                // Core resumed under us: park the request until the pause is re-acknowledged.
                if (!pend) begin
                  pend           <= 1'b1;
                  pend_addr      <= bus.ioctl_addr;
                  bus.ioctl_wait <= 1'b1;
                end
              end else begin
                pend <= 1'b0;
                if (addr_in_range(req_addr, SIZE)) begin
                  bus.ram_addr   <= req_addr[ADDR_W-1:0];
                  bus.ram_rd     <= 1'b1;
                  bus.ioctl_wait <= 1'b1;
                  cnt            <= CntW'(RAM_LAT);
                  state          <= StFetch;
                end else begin
                  bus.ioctl_din  <= PAD;
                  bus.ioctl_wait <= 1'b0;
                end
              end
            end
          end
          StFetch: begin
            // Reads arriving here violate the wait handshake and are dropped.
            if (cnt == '0) begin
              bus.ioctl_din  <= bus.ram_do;
              bus.ioctl_wait <= 1'b0;
              state          <= StReady;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hiscore_upload_src.sv
// Randomized self-checking bench for hiscore_upload_src against a transaction-level model
// of the upload protocol and a behavioural core RAM with fixed read latency.
module tb_hiscore_upload_src;
  import hiscore_upload_src_pkg::*;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned SIZE    = 1024;
  localparam int unsigned RAM_LAT = 2;
  localparam logic [7:0]  INDEX   = 8'd4;
  localparam logic [7:0]  PAD     = 8'hFF;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  hiscore_upload_src_if #(.ADDR_W(ADDR_W)) bus ();

  hiscore_upload_src #(
    .INDEX  (INDEX),
    .ADDR_W (ADDR_W),
    .SIZE   (SIZE),
    .RAM_LAT(RAM_LAT),
    .PAD    (PAD)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus)
  );

  // Core RAM: data valid RAM_LAT cycles after the strobe, junk otherwise.
  logic [7:0] mem  [SIZE];
  logic [7:0] pipe [RAM_LAT];
  always @(posedge clk_sys) begin
    pipe[0] <= bus.ram_rd ? mem[bus.ram_addr] : 8'hEE;
    for (int k = 1; k < RAM_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign bus.ram_do = pipe[RAM_LAT-1];

  int total = 0;
  int bad   = 0;
  int unsigned rd_pulses = 0;
  logic [ADDR_W-1:0] last_ram_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Session flags follow the selection seen at each edge; every RAM strobe is logged.
  initial forever begin
    logic sel_e;
    logic rst_e;
    @(posedge clk_sys);
    sel_e = bus.ioctl_upload && (bus.ioctl_index == INDEX);
    rst_e = reset;
    #2;
    if (!rst_e && !reset) begin
      check("busy", 32'(bus.busy), 32'(sel_e));
      check("pause_req", 32'(bus.pause_req), 32'(sel_e));
      if (bus.ram_rd) begin
        rd_pulses++;
        last_ram_addr = bus.ram_addr;
        check("ram_rd_outside_session", 32'(bus.busy), 32'd1);
      end
    end
  end

  task automatic start_session(input logic [7:0] idx, input int ack_dly);
    bus.ioctl_index  = idx;
    bus.ioctl_upload = 1'b1;
    tick(1);
    if (ack_dly >= 0) begin
      tick(ack_dly);
      bus.pause_ack = 1'b1;
      tick(1);
    end
  endtask

  task automatic end_session();
    bus.ioctl_upload = 1'b0;
    bus.pause_ack    = 1'b0;
    tick(2);
  endtask

  task automatic wait_drop(output int waits);
    waits = 0;
    while (bus.ioctl_wait && waits < 40) begin
      waits++;
      tick(1);
    end
  endtask

  task automatic do_read(input logic [24:0] a, input string tag);
    int unsigned p0;
    int waits;
    logic [7:0] exp;
    logic in_range;
    in_range = a < SIZE;
    exp = in_range ? mem[a[ADDR_W-1:0]] : PAD;
    p0 = rd_pulses;
    bus.ioctl_rd   = 1'b1;
    bus.ioctl_addr = a;
    tick(1);
    bus.ioctl_rd = 1'b0;
    wait_drop(waits);
    check({tag, "_wait_cycles"}, waits, in_range ? RAM_LAT + 1 : 0);
    check({tag, "_din"}, 32'(bus.ioctl_din), 32'(exp));
    check({tag, "_ram_rd_count"}, rd_pulses - p0, in_range ? 1 : 0);
    if (in_range) check({tag, "_ram_addr"}, 32'(last_ram_addr), 32'(a[ADDR_W-1:0]));
  endtask

  task automatic ack_drop_read(input logic [24:0] a);
    int unsigned p0;
    int waits;
    int hold;
    logic [7:0] exp;
    exp = mem[a[ADDR_W-1:0]];
    bus.pause_ack = 1'b0;
    tick(1);
    p0 = rd_pulses;
    bus.ioctl_rd   = 1'b1;
    bus.ioctl_addr = a;
    tick(1);
    bus.ioctl_rd = 1'b0;
    hold = $urandom_range(1, 4);
    for (int i = 0; i < hold; i++) begin
      check("ackdrop_wait_held", 32'(bus.ioctl_wait), 32'd1);
      tick(1);
    end
    check("ackdrop_no_ram_rd", rd_pulses - p0, 0);
    bus.pause_ack = 1'b1;
    wait_drop(waits);
    check("ackdrop_wait_bounded", 32'(waits < 40), 32'd1);
    check("ackdrop_din", 32'(bus.ioctl_din), 32'(exp));
    check("ackdrop_ram_rd_count", rd_pulses - p0, 1);
  endtask

  initial begin
    int unsigned p0;
    int waits;
    logic [24:0] a;
    logic [7:0] old_din;

    bus.ioctl_upload = 1'b0;
    bus.ioctl_index  = 8'd0;
    bus.ioctl_rd     = 1'b0;
    bus.ioctl_addr   = '0;
    bus.pause_ack    = 1'b0;
    for (int i = 0; i < SIZE; i++) mem[i] = 8'(i);

    tick(2);
    check("rst_din", 32'(bus.ioctl_din), 32'd0);
    check("rst_wait", 32'(bus.ioctl_wait), 32'd0);
    check("rst_pause_req", 32'(bus.pause_req), 32'd0);
    check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    check("rst_ram_rd", 32'(bus.ram_rd), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    tick(2);

    // Basic read after a 3-cycle pause handshake.
    start_session(INDEX, 2);
    check("t1_pause_req", 32'(bus.pause_req), 32'd1);
    do_read(25'h005, "t1");
    check("t1_literal_din", 32'(bus.ioctl_din), 32'h05);
    do_read(25'h400, "pad");
    check("pad_literal_din", 32'(bus.ioctl_din), 32'hFF);

    // Read during an active fetch must be ignored.
    p0 = rd_pulses;
    bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'h010;
    tick(1);
    bus.ioctl_addr = 25'h020;
    tick(1);
    bus.ioctl_rd = 1'b0;
    wait_drop(waits);
    check("viol_din", 32'(bus.ioctl_din), 32'h10);
    check("viol_ram_rd_count", rd_pulses - p0, 1);
    end_session();

    // Wrong slot: nothing may happen.
    p0 = rd_pulses;
    start_session(RomIndex, -1);
    bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'h005;
    tick(1);
    bus.ioctl_rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("idx0_wait", 32'(bus.ioctl_wait), 32'd0);
      tick(1);
    end
    check("idx0_ram_rd_count", rd_pulses - p0, 0);
    end_session();

    // Request before pause_ack is held and serviced once the core halts.
    start_session(INDEX, -1);
    tick(1);
    p0 = rd_pulses;
    bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'h123;
    tick(1);
    bus.ioctl_rd = 1'b0;
    check("pend_wait_early", 32'(bus.ioctl_wait), 32'd1);
    tick(3);
    check("pend_wait_held", 32'(bus.ioctl_wait), 32'd1);
    check("pend_no_ram_rd", rd_pulses - p0, 0);
    bus.pause_ack = 1'b1;
    tick(1);
    check("pend_ram_rd_not_yet", 32'(bus.ram_rd), 32'd0);
    tick(1);
    check("pend_ram_rd_fires", 32'(bus.ram_rd), 32'd1);
    wait_drop(waits);
    check("pend_literal_din", 32'(bus.ioctl_din), 32'h23);
    check("pend_ram_rd_count", rd_pulses - p0, 1);

    // Full sweep over random RAM contents.
    for (int i = 0; i < SIZE; i++) mem[i] = 8'($urandom);
    p0 = rd_pulses;
    for (int i = 0; i < SIZE; i++) do_read(25'(i), "seq");
    check("seq_total_ram_rd", rd_pulses - p0, SIZE);

    // Random mix of reads, pause-ack glitches and session restarts.
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: do_read(25'($urandom_range(0, SIZE - 1)), "rnd");
        4: begin
          a = 25'($urandom);
          if (a < SIZE) a = a + 25'(SIZE);
          do_read(a, "rndpad");
        end
        5, 6: ack_drop_read(25'($urandom_range(0, SIZE - 1)));
        7: do_read(25'(SIZE) + 25'($urandom_range(0, 3)) * 25'(SIZE), "alias");
        default: begin
          end_session();
          if ($urandom_range(0, 1) == 1) begin
            start_session(DipIndex, -1);
            tick(2);
            end_session();
          end
          start_session(INDEX, int'($urandom_range(0, 4)));
        end
      endcase
    end

    // Abort in the middle of a fetch: din keeps its prior byte.
    do_read(25'h033, "abort_pre");
    old_din = bus.ioctl_din;
    bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'h044;
    tick(1);
    bus.ioctl_rd = 1'b0;
    bus.ioctl_upload = 1'b0;
    tick(1);
    check("abort_wait", 32'(bus.ioctl_wait), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_pause_req", 32'(bus.pause_req), 32'd0);
    tick(4);
    check("abort_din_held", 32'(bus.ioctl_din), 32'(old_din));
    bus.pause_ack = 1'b0;
    tick(1);

    // Asynchronous reset while waiting for the pause.
    start_session(INDEX, -1);
    tick(1);
    check("pause_busy", 32'(bus.busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_wait", 32'(bus.ioctl_wait), 32'd0);
    check("arst_pause_req", 32'(bus.pause_req), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_ram_rd", 32'(bus.ram_rd), 32'd0);
    check("arst_din", 32'(bus.ioctl_din), 32'd0);
    bus.ioctl_upload = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(2);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    start_session(INDEX, 1);
    do_read(25'h0AB, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
